ram_read_seq: RTL and testbench

RAM_READ_SEQ -- requirements
Module: ram_read_seq

---
 rtl/ram_rd_pkg.sv | 16 +
 rtl/rd_skid_buf.sv | 57 +++++
 rtl/ram_read_seq.sv | 117 +++++++++++
 tb/tb_ram_read_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// Shared constants and FSM state type for the RAM read sequencer.
package ram_rd_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int BUF_DEPTH      = 2;
    localparam int BUF_CNT_W      = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order valid/ready buffer; the head entry drives the output.
module rd_skid_buf
    import ram_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk_B,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 ready,
    output logic                 valid,
    output logic [WIDTH-1:0]     data,
    output logic [BUF_CNT_W-1:0] count
);

    localparam logic [BUF_CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop;

    assign valid = (count != '0);
    assign pop   = valid && ready;
    assign data  = head;

    // The producer never pushes into a full buffer, so no overflow path exists.
    always_ff @(posedge clk_B or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) head <= push_data;
                    else             tail <= push_data;
                    count <= count + CNT_ONE;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - CNT_ONE;
                end
                2'b11: begin
                    if (count == CNT_ONE) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_read_seq.sv
// Burst reader: streams LENGTH words from a synchronous RAM through a 2-entry buffer.
// Define RAM_RD_PARITY_EN to add PARITY_OUT (even parity of DATA_OUT).
module ram_read_seq
    import ram_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_B,
    input  logic                  rst_n,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH:0]   LENGTH,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic                  ENABLE_R,
    input  logic [DATA_WIDTH-1:0] RAM_DATA,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  BUSY,
    output logic                  DONE
`ifdef RAM_RD_PARITY_EN
    ,
    output logic                  PARITY_OUT
`endif
);

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [BUF_CNT_W-1:0]  CNT_ONE  = 1;

    rd_state_t             state;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  rd_pend;
    logic [BUF_CNT_W-1:0]  count;
    logic                  pop;
    logic [BUF_CNT_W:0]    occ;
    logic                  drained;

    assign pop = VALID && READY;
    // Occupancy once this cycle's transfer leaves; counting the pop keeps one word per cycle.
    assign occ = {1'b0, count} + {{BUF_CNT_W{1'b0}}, rd_pend} - {{BUF_CNT_W{1'b0}}, pop};

    assign ENABLE_R = (state == ST_READ) && (issued != len_q) && (occ < 2);
    assign RAM_ADDR = ENABLE_R ? next_addr : last_addr;
    assign BUSY     = (state != ST_IDLE);
    assign DONE     = (state == ST_FINISH);
    assign drained  = !rd_pend && ((count == '0) || ((count == CNT_ONE) && pop));

    always_ff @(posedge clk_B or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            issued    <= '0;
            next_addr <= '0;
            last_addr <= '0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= ENABLE_R;
            if (ENABLE_R) begin
                issued    <= issued + LEN_ONE;
                next_addr <= next_addr + ADDR_ONE;
                last_addr <= next_addr;
            end
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        len_q     <= LENGTH;
                        next_addr <= BASE_ADDR;
                        issued    <= '0;
                        state     <= (LENGTH == '0) ? ST_FINISH : ST_READ;
                    end
                end
                ST_READ: begin
                    if (ENABLE_R && (issued + LEN_ONE == len_q)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drained) state <= ST_FINISH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RAM_RD_PARITY_EN
    localparam int BUF_W = DATA_WIDTH + 1;
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;
    assign buf_in     = {^RAM_DATA, RAM_DATA};
    assign DATA_OUT   = buf_out[DATA_WIDTH-1:0];
    assign PARITY_OUT = buf_out[DATA_WIDTH];
`else
    localparam int BUF_W = DATA_WIDTH;
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;
    assign buf_in   = RAM_DATA;
    assign DATA_OUT = buf_out;
`endif

    // rd_pend marks RAM_DATA as valid this cycle; after reset it is clear, so stale data is dropped.
    rd_skid_buf #(
        .WIDTH (BUF_W)
    ) u_buf (
        .clk_B     (clk_B),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (buf_in),
        .ready     (READY),
        .valid     (VALID),
        .data      (buf_out),
        .count     (count)
    );

endmodule

// File: tb/tb_ram_read_seq.sv
// Randomized bench for ram_read_seq against a burst-level queue model and a behavioural RAM.
module tb_ram_read_seq;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk_B     = 1'b0;
    logic          rst_n     = 1'b0;
    logic          START     = 1'b0;
    logic [AW-1:0] BASE_ADDR = '0;
    logic [AW:0]   LENGTH    = '0;
    logic [AW-1:0] RAM_ADDR;
    logic          ENABLE_R;
    logic [DW-1:0] RAM_DATA  = '0;
    logic [DW-1:0] DATA_OUT;
    logic          VALID;
    logic          READY     = 1'b1;
    logic          BUSY;
    logic          DONE;
`ifdef RAM_RD_PARITY_EN
    logic          PARITY_OUT;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_mode = 0;
    int rpat = 0;

    logic [DW-1:0] mem [16];

    // burst-level reference model
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];
    logic [AW-1:0] last_addr = '0;
    bit            m_active = 1'b0;
    int            m_done_cyc = -1;
    int            b_start_cyc = 0;
    int            b_first_valid = -1;
    int            b_last_xfer = 0;
    int            b_xfer = 0;
    int            b_issue = 0;
    int            b_done = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    bit            m_xfer;
    logic [DW-1:0] m_e;

    ram_read_seq dut (
        .clk_B      (clk_B),
        .rst_n      (rst_n),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .LENGTH     (LENGTH),
        .RAM_ADDR   (RAM_ADDR),
        .ENABLE_R   (ENABLE_R),
        .RAM_DATA   (RAM_DATA),
        .DATA_OUT   (DATA_OUT),
        .VALID      (VALID),
        .READY      (READY),
        .BUSY       (BUSY),
        .DONE       (DONE)
`ifdef RAM_RD_PARITY_EN
        ,
        .PARITY_OUT (PARITY_OUT)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always #5 clk_B = ~clk_B;
    always @(posedge clk_B) cyc <= cyc + 1;

    // synchronous-read RAM: data follows one cycle after ENABLE_R is sampled
    always @(posedge clk_B) if (ENABLE_R) RAM_DATA <= mem[RAM_ADDR];

    always @(posedge clk_B) begin
        #1;
        case (ready_mode)
            0: READY = 1'b1;
            1: READY = 1'($urandom_range(0, 1));
            default: begin
                READY = ((rpat % 4) == 0) || ((rpat % 4) == 3);
                rpat++;
            end
        endcase
    end

    // Per-cycle model update and checks, sampled mid-cycle when inputs are settled.
    always @(negedge clk_B or negedge rst_n) begin
        if (!rst_n) begin
            exp_data.delete();
            exp_addr.delete();
            last_addr  = '0;
            m_active   = 1'b0;
            m_done_cyc = -1;
            stall_prev = 1'b0;
        end else begin
            m_xfer = VALID && READY;
            chk("busy", 32'(BUSY), 32'(m_active));
            chk("done", 32'(DONE), 32'(m_active && (cyc == m_done_cyc)));
            if (!m_active) chk("valid_idle", 32'(VALID), 0);
            if (stall_prev) begin
                chk("stall_valid", 32'(VALID), 1);
                chk("stall_data", 32'(DATA_OUT), 32'(stall_data));
            end
            if (ENABLE_R) begin
                chk("occupancy", 32'((b_issue - b_xfer - int'(m_xfer)) < 2), 1);
                if (exp_addr.size() == 0) begin
                    chk("extra_read", 32'(ENABLE_R), 0);
                end else begin
                    chk("rd_addr", 32'(RAM_ADDR), 32'(exp_addr[0]));
                    last_addr = exp_addr.pop_front();
                end
                b_issue++;
            end else begin
                chk("addr_hold", 32'(RAM_ADDR), 32'(last_addr));
            end
            // START sampled at edge k; first word is visible after edge k+2
            if (m_active && VALID && b_first_valid < 0) begin
                b_first_valid = cyc;
                chk("first_valid", 32'(cyc - b_start_cyc), 3);
            end
            if (m_xfer) begin
                if (exp_data.size() == 0) begin
                    chk("extra_xfer", 32'(m_xfer), 0);
                end else begin
                    m_e = exp_data.pop_front();
                    chk("data", 32'(DATA_OUT), 32'(m_e));
`ifdef RAM_RD_PARITY_EN
                    chk("parity", 32'(PARITY_OUT), 32'(^m_e));
`endif
                    if (ready_mode == 0 && b_xfer > 0) chk("throughput", 32'(cyc - b_last_xfer), 1);
                    b_xfer++;
                    b_last_xfer = cyc;
                    if (exp_data.size() == 0) m_done_cyc = cyc + 1;
                end
            end
            if (DONE) b_done++;
            stall_prev = VALID && !READY;
            stall_data = DATA_OUT;
            if (m_active && cyc == m_done_cyc) begin
                m_active = 1'b0;
            end else if (!m_active && START) begin
                m_active      = 1'b1;
                b_start_cyc   = cyc;
                b_first_valid = -1;
                b_xfer        = 0;
                b_issue       = 0;
                b_done        = 0;
                for (int i = 0; i < int'(LENGTH); i++) begin
                    exp_addr.push_back(AW'(int'(BASE_ADDR) + i));
                    exp_data.push_back(mem[AW'(int'(BASE_ADDR) + i)]);
                end
                if (LENGTH == '0) m_done_cyc = cyc + 1;
            end
        end
    end

    task automatic start_burst(input int base, input int len);
        @(posedge clk_B); #1;
        START     = 1'b1;
        BASE_ADDR = AW'(base);
        LENGTH    = (AW+1)'(len);
        @(posedge clk_B); #1;
        START     = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && m_active; k++) @(posedge clk_B);
        chk("burst_timeout", 32'(m_active), 0);
        @(posedge clk_B); #1;
        chk("busy_low", 32'(BUSY), 0);
    endtask

    task automatic end_checks(input int len);
        chk("xfer_cnt", 32'(b_xfer), 32'(len));
        chk("issue_cnt", 32'(b_issue), 32'(len));
        chk("done_cnt", 32'(b_done), 1);
    endtask

    task automatic check_reset();
        chk("rst_ram_addr", 32'(RAM_ADDR), 0);
        chk("rst_enable_r", 32'(ENABLE_R), 0);
        chk("rst_data_out", 32'(DATA_OUT), 0);
        chk("rst_valid", 32'(VALID), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(DONE), 0);
`ifdef RAM_RD_PARITY_EN
        chk("rst_parity", 32'(PARITY_OUT), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int l;
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);

        repeat (3) @(posedge clk_B);
        #1;
        check_reset();
        rst_n = 1'b1;

        // straight burst, wrap-around burst, stalled burst
        ready_mode = 0;
        start_burst(0, 4);
        wait_idle();
        end_checks(4);
        start_burst(14, 4);
        wait_idle();
        end_checks(4);
        ready_mode = 2;
        start_burst(3, 4);
        wait_idle();
        end_checks(4);

        // empty burst, then a long burst with a stray START inside it
        ready_mode = 0;
        start_burst(7, 0);
        wait_idle();
        end_checks(0);
        start_burst(2, 16);
        repeat (5) @(posedge clk_B);
        #1;
        START = 1'b1; BASE_ADDR = 4'd9; LENGTH = 5'd3;
        @(posedge clk_B); #1;
        START = 1'b0;
        wait_idle();
        end_checks(16);

        ready_mode = 1;
        for (int n = 0; n < 10; n++) begin
            b = $urandom_range(0, 15);
            l = $urandom_range(0, 16);
            start_burst(b, l);
            wait_idle();
            end_checks(l);
        end

        // reset in the middle of a burst
        ready_mode = 0;
        start_burst(0, 8);
        for (int k = 0; k < 50 && b_xfer < 3; k++) @(posedge clk_B);
        #2;
        chk("xfers_before_rst", 32'(b_xfer), 3);
        rst_n = 1'b0;
        #1;
        check_reset();
        repeat (2) @(posedge clk_B);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk_B);
        start_burst(5, 2);
        wait_idle();
        end_checks(2);

        repeat (3) @(posedge clk_B);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
